// File: rtl/ota_pdm_driver_pkg.sv
// Shared types and constants for the OTA pulse-density-modulation driver.
package ota_pdm_driver_pkg;

    // Default PDM code width; a frame lasts 2**CODE_W clock cycles.
    localparam int CODE_W_DEFAULT = 8;

    // Driver control states: waiting for a code, or emitting a frame.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/pdm_accum.sv
// First-order PDM accumulator. The carry out of acc + code is the PDM bit for
// the current cycle. Over 2**CODE_W consecutive enabled cycles that start from
// a cleared accumulator, the carry is high exactly `code` times.
module pdm_accum
    import ota_pdm_driver_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [CODE_W-1:0] code,
    output logic              pdm_bit
);

    logic [CODE_W-1:0] acc_q;
    logic [CODE_W:0]   sum;

    // Widen by one bit so the overflow of acc + code becomes the carry.
    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, code};
        pdm_bit = sum[CODE_W];
    end

    // Clear takes priority over stepping, so a new frame always starts from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= sum[CODE_W-1:0];
        end
    end

endmodule

// File: rtl/ota_pdm_driver.sv
// OTA differential PDM driver. Accepts a pulse-density code over a
// valid/ready handshake and drives vip/vin with a complementary PDM stream,
// one frame of 2**CODE_W cycles per accepted code. Frames chain without a gap
// when a new code is accepted in the last cycle of the current frame.
module ota_pdm_driver
    import ota_pdm_driver_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    output logic              code_ready,
    output logic              vip,
    output logic              vin,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned       FRAME_LEN   = 2 ** CODE_W;
    localparam logic [CODE_W-1:0] FCNT_LAST   = CODE_W'(FRAME_LEN - 1);
    localparam logic [CODE_W-1:0] FCNT_PENULT = CODE_W'(FRAME_LEN - 2);

    state_t            state_q;
    state_t            state_d;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] fcnt_q;
    logic              vip_q;
    logic              vin_q;
    logic              frame_done_q;

    logic              is_run;
    logic              last_cycle;
    logic              xfer;
    logic              acc_clr;
    logic              drive;
    logic              carry;

    // Frame position decode and handshake qualification.
    always_comb begin
        is_run     = (state_q == RUN);
        last_cycle = is_run && (fcnt_q == FCNT_LAST);
        code_ready = ena && ((state_q == IDLE) || last_cycle);
        xfer       = code_valid && code_ready;
        // A new code or a disable both restart the accumulator from zero.
        acc_clr    = xfer || !ena;
        // The bridge is only driven while a frame runs with the block enabled.
        drive      = is_run && ena;
    end

    // Next-state logic: disable wins, otherwise a frame ends or chains on its
    // last cycle depending on whether a new code was taken.
    always_comb begin
        state_d = state_q;
        if (!ena) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (last_cycle) begin
                        state_d = xfer ? RUN : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Code register, loaded only on an accepted handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= '0;
        end else if (xfer) begin
            code_q <= code_in;
        end
    end

    // Frame cycle counter; wraps to 0 naturally after the last cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= '0;
        end else if (acc_clr) begin
            fcnt_q <= '0;
        end else if (is_run) begin
            fcnt_q <= fcnt_q + 1'b1;
        end
    end

    pdm_accum #(
        .CODE_W (CODE_W)
    ) u_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (acc_clr),
        .en      (is_run),
        .code    (code_q),
        .pdm_bit (carry)
    );

    // Output drive registers; both legs are pulled low whenever not driving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vip_q <= 1'b0;
            vin_q <= 1'b0;
        end else begin
            vip_q <= drive & carry;
            vin_q <= drive & ~carry;
        end
    end

    // frame_done is registered one cycle early so it is high exactly while
    // the counter sits on the last frame cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= drive && !xfer && (fcnt_q == FCNT_PENULT);
        end
    end

    assign vip        = vip_q;
    assign vin        = vin_q;
    assign busy       = is_run;
    assign frame_done = frame_done_q;

endmodule

// File: doc/ota_pdm_driver.md
OTA_PDM_DRIVER -- requirements
Module: ota_pdm_driver

Interface
REQ-001 SHALL have parameter CODE_W, default 8, PDM code width; frame length is 2**CODE_W cycles.
REQ-002 SHALL have port clk  input  1  the single clock for all sequential logic.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port ena  input  1  block enable; low forces IDLE.
REQ-005 SHALL have port code_in  input  CODE_W  target pulse density (ones per frame).
REQ-006 SHALL have port code_valid  input  1  code_in offered by the source.
REQ-007 SHALL have port code_ready  output  1  block accepts code_in this cycle.
REQ-008 SHALL have port vip  output  1  registered PDM drive to the OTA non-inverting input.
REQ-009 SHALL have port vin  output  1  registered complementary drive to the OTA inverting input.
REQ-010 SHALL have port busy  output  1  high while a frame is running.
REQ-011 SHALL have port frame_done  output  1  single-cycle pulse in the last cycle of each frame.

Function
REQ-012 SHALL implement FSM states IDLE and RUN only.
REQ-013 IDLE: code_ready = ena; vip = vin = 0; busy = 0.
REQ-014 Handshake: a transfer occurs on a rising clk edge where code_valid && code_ready; code_in is captured into code_q.
REQ-015 code_valid without code_ready SHALL have no effect; the source holds data until transfer.
REQ-016 Transfer in IDLE SHALL move to RUN, clear accumulator acc and frame counter fcnt to 0.
REQ-017 RUN, each cycle: {carry, acc} = acc + code_q (CODE_W+1-bit sum); acc takes the low CODE_W bits; fcnt increments, wrapping modulo 2**CODE_W.
REQ-018 vip SHALL register carry; vin SHALL register ~carry; first PDM bit appears on vip one cycle after the transfer edge.
REQ-019 Exactly code_q ones SHALL appear on vip per 2**CODE_W-cycle frame (code 0: all zeros; all-ones code: 2**CODE_W-1 ones).
REQ-020 frame_done and code_ready SHALL be high in the RUN cycle where fcnt == 2**CODE_W-1 (code_ready also requires ena).
REQ-021 Transfer in the last frame cycle SHALL start the next frame back-to-back with the new code, acc and fcnt cleared, no gap cycle on vip/vin.
REQ-022 No transfer in the last frame cycle SHALL return the FSM to IDLE; vip/vin go 0 the following cycle.
REQ-023 code_ready SHALL be low in RUN except in the last frame cycle.
REQ-024 ena deasserted in any state SHALL force IDLE on the next edge, abort the frame, suppress frame_done, and clear acc/fcnt.
REQ-025 ena low and a handshake in the same cycle: no transfer, since code_ready is low.
REQ-026 busy SHALL equal (state == RUN).

Reset
REQ-027 rst_n low SHALL asynchronously set state = IDLE, code_q = 0, acc = 0, fcnt = 0, vip = 0, vin = 0, frame_done = 0.
REQ-028 Reset asserted mid-frame SHALL abort immediately with no partial frame_done.
REQ-029 Reset deassertion SHALL be synchronous-release safe; first transfer possible on the first edge after release.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, RUN) and the default CODE_W constant.
REQ-031 The accumulator and carry generation SHALL be a sub-module pdm_accum (inputs clk, rst_n, clr, en, code; output bit).
REQ-032 All outputs SHALL be registered; no combinational path from code_in to vip/vin.

Verification
REQ-033 Reset, ena=1, code_in=8'd64 transferred -> exactly 64 ones on vip over the next 256 cycles, vin == ~vip every cycle, one frame_done.
REQ-034 code_in=8'd0 then 8'd255 back-to-back -> 256 cycles vip=0/vin=1, then 255 ones in 256 cycles, no idle gap between frames.
REQ-035 code_in=8'd128 -> vip alternates 0,1,0,1... from the first PDM bit.
REQ-036 ena dropped at frame cycle 100 -> next cycle vip=vin=0, busy=0, no frame_done; code_ready stays low until ena returns.
REQ-037 rst_n pulsed low mid-frame (between edges) -> vip, vin, busy, frame_done all 0 immediately, with no clock edge needed.
REQ-038 code_valid held high with changing code_in during RUN -> only the value present in the last frame cycle is accepted.
